// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder; every carry is a flat sum of products of g/p/cin.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded directly from cin so no carry waits on a lower one.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_seq.sv
// Multi-cycle WIDTH-bit adder: one cla4_slice reused LSB nibble first, carry chained in a flop.
// Optional signed-overflow output out_ovf is built when CLA_SEQ_OVF_EN is defined.
module cla_nibble_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t                state;
  logic [IDXW-1:0]       idx;
  logic                  carry;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [NIBBLE_W-1:0]   nib_s;
  logic                  nib_cout;

  cla4_slice u_slice (
    .a    (a_q[idx*NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[idx*NIBBLE_W +: NIBBLE_W]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: all state here is updated with non-blocking assignments so every flop
  // sees the pre-edge value of idx/carry, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry   <= in_cin;
            idx     <= '0;
            out_sum <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          out_sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry <= nib_cout;
          idx   <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            out_cout <= nib_cout;
`ifdef CLA_SEQ_OVF_EN
            // Same-sign operands whose sum flips sign: two's-complement overflow.
            out_ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Scoreboard bench for cla_nibble_seq at WIDTH=16 and WIDTH=32 against an arithmetic model.
module tb_cla_nibble_seq;

  localparam int W16 = 16, W32 = 32;
  localparam int NIB16 = 4, NIB32 = 8;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          edge_n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [15:0] in_a, in_b, out_sum;
  logic        in_valid32, in_ready32, in_cin32, out_valid32, out_ready32, out_cout32, busy32;
  logic [31:0] in_a32, in_b32, out_sum32;
`ifdef CLA_SEQ_OVF_EN
  logic        out_ovf, out_ovf32;
`endif

  cla_nibble_seq #(.WIDTH(W16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
`ifdef CLA_SEQ_OVF_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );

  cla_nibble_seq #(.WIDTH(W32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_a(in_a32), .in_b(in_b32), .in_cin(in_cin32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_sum(out_sum32), .out_cout(out_cout32),
`ifdef CLA_SEQ_OVF_EN
    .out_ovf(out_ovf32),
`endif
    .busy(busy32)
  );

  int   cyc = 0;
  int   checks = 0, fails = 0;
  exp_t q16[$], q32[$];
  int   last_hs16 = 0, last_hs32 = 0;
  bit   b2b16 = 0, b2b32 = 0, vseen16 = 0, vseen32 = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer sum, and signed overflow as "true signed result out of range".
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input int e);
    exp_t r;
    logic [63:0] total;
    longint sa, sb, st, lim;
    total    = 64'(a) + 64'(b) + 64'(cin);
    r.sum    = 32'(total & ((64'd1 << w) - 64'd1));
    r.cout   = total[w];
    lim      = longint'(1) << (w - 1);
    sa       = longint'(64'(a));
    sb       = longint'(64'(b));
    if (a[w-1]) sa = sa - (lim << 1);
    if (b[w-1]) sb = sb - (lim << 1);
    st       = sa + sb + longint'(cin);
    r.ovf    = (st >= lim) || (st < -lim);
    r.edge_n = e;
    return r;
  endfunction

  // Accept monitors: push the expected response when an input handshake will occur at the next edge.
  always @(negedge clk) begin : acc16
    if (rst_n && in_valid && in_ready) begin
      if (b2b16 && last_hs16 != 0) check("b2b_accept_edge16", 64'(cyc + 1), 64'(last_hs16 + 1));
      q16.push_back(model(W16, 32'(in_a), 32'(in_b), in_cin, cyc + 1));
    end
  end

  always @(negedge clk) begin : acc32
    if (rst_n && in_valid32 && in_ready32) begin
      if (b2b32 && last_hs32 != 0) check("b2b_accept_edge32", 64'(cyc + 1), 64'(last_hs32 + 1));
      q32.push_back(model(W32, in_a32, in_b32, in_cin32, cyc + 1));
    end
  end

  // Output monitors: latency on the first DONE cycle, data on the output handshake.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst_n) vseen16 = 0;
    else begin
      if (out_valid && !vseen16) begin
        vseen16 = 1;
        if (q16.size() == 0) check("spurious_out_valid16", 64'(out_valid), 64'd0);
        else check("latency16", 64'(cyc - q16[0].edge_n), 64'(NIB16));
      end
      if (out_valid && out_ready && q16.size() != 0) begin
        e = q16.pop_front();
        check("sum16", 64'(out_sum), 64'(e.sum));
        check("cout16", 64'(out_cout), 64'(e.cout));
`ifdef CLA_SEQ_OVF_EN
        check("ovf16", 64'(out_ovf), 64'(e.ovf));
`endif
        last_hs16 = cyc + 1;
        vseen16   = 0;
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst_n) vseen32 = 0;
    else begin
      if (out_valid32 && !vseen32) begin
        vseen32 = 1;
        if (q32.size() == 0) check("spurious_out_valid32", 64'(out_valid32), 64'd0);
        else check("latency32", 64'(cyc - q32[0].edge_n), 64'(NIB32));
      end
      if (out_valid32 && out_ready32 && q32.size() != 0) begin
        e = q32.pop_front();
        check("sum32", 64'(out_sum32), 64'(e.sum));
        check("cout32", 64'(out_cout32), 64'(e.cout));
`ifdef CLA_SEQ_OVF_EN
        check("ovf32", 64'(out_ovf32), 64'(e.ovf));
`endif
        last_hs32 = cyc + 1;
        vseen32   = 0;
      end
    end
  end

  task automatic drive(input bit wide, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic v);
    if (wide) begin
      in_a32 = a; in_b32 = b; in_cin32 = cin; in_valid32 = v;
    end else begin
      in_a = a[15:0]; in_b = b[15:0]; in_cin = cin; in_valid = v;
    end
  endtask

  function automatic bit accepting(input bit wide);
    return wide ? (in_valid32 && in_ready32) : (in_valid && in_ready);
  endfunction

  task automatic wait_accept(input bit wide);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!accepting(wide) && n < 50);
    if (!accepting(wide)) check("accept_timeout", 64'(wide ? in_ready32 : in_ready), 64'd1);
  endtask

  task automatic drain(input bit wide);
    int n = 0;
    while ((wide ? q32.size() : q16.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(wide ? q32.size() : q16.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic op(input bit wide, input logic [31:0] a, input logic [31:0] b, input logic cin);
    drive(wide, a, b, cin, 1'b1);
    wait_accept(wide);
    @(posedge clk); #1;
    if (wide) in_valid32 = 1'b0; else in_valid = 1'b0;
    drain(wide);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(7))
      0: v = '1;
      1: v = '0;
      default: ;
    endcase
    return v;
  endfunction

  // in_valid stays high throughout so each accept must follow the previous output handshake.
  task automatic rand_b2b(input bit wide, input int n);
    if (wide) begin b2b32 = 1; last_hs32 = 0; end
    else begin b2b16 = 1; last_hs16 = 0; end
    drive(wide, rnd_operand(), rnd_operand(), 1'($urandom_range(1)), 1'b1);
    for (int i = 0; i < n; i++) begin
      wait_accept(wide);
      @(posedge clk); #1;
      drive(wide, rnd_operand(), rnd_operand(), 1'($urandom_range(1)), (i != n - 1));
    end
    drain(wide);
    b2b16 = 0;
    b2b32 = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    exp_t e;
    int   n;
    logic [15:0] sa, sb;
    logic        sc;

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    out_ready32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed boundaries.
    op(1'b0, 32'hFFFF, 32'h0001, 1'b0);
    op(1'b0, 32'h1234, 32'h4321, 1'b1);
    op(1'b0, 32'h0000, 32'h0000, 1'b0);
    op(1'b0, 32'hFFFF, 32'hFFFF, 1'b1);
    op(1'b0, 32'h7FFF, 32'h0001, 1'b0);
    op(1'b0, 32'h8000, 32'h8000, 1'b0);

    // Output stall: result held, in_valid pulses ignored.
    out_ready = 1'b0;
    sa = 16'($urandom()); sb = 16'($urandom()); sc = 1'($urandom_range(1));
    e  = model(W16, 32'(sa), 32'(sb), sc, 0);
    drive(1'b0, 32'(sa), 32'(sb), sc, 1'b1);
    wait_accept(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("stall_reach_done", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("stall_sum", 64'(out_sum), 64'(e.sum));
      check("stall_cout", 64'(out_cout), 64'(e.cout));
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_a = 16'($urandom());
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("stall_queue_empty", 64'(q16.size()), 64'd0);

    // Reset while RUN is at idx=2: transaction must vanish.
    drive(1'b0, 32'hABCD, 32'h1357, 1'b1, 1'b1);
    wait_accept(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    check("midrst_out_cout", 64'(out_cout), 64'd0);
`ifdef CLA_SEQ_OVF_EN
    check("midrst_out_ovf", 64'(out_ovf), 64'd0);
`endif
    q16.delete();
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrst_no_out_valid", 64'(n), 64'd0);
    @(posedge clk); #1;

    // Random back-to-back streams at both widths.
    rand_b2b(1'b0, 1000);
    op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    op(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    rand_b2b(1'b1, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
